// File: rtl/heart_beat_ctrl.sv
// Frame-synchronous attack/hold/decay envelope controller for the heart renderer.
// Latency: outputs update one cycle after frame_tick (memories also one cycle after clr_mem).
// Backpressure: none; the sample stream is consumed every cycle and outputs hold between ticks.
module heart_beat_ctrl #(
  parameter int HOLD_FRAMES = 8,
  parameter int DECAY_STEP  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] size_sel,
  input  logic       frame_tick,
  input  logic [9:0] sample_in,
  input  logic       sample_valid,
  input  logic       clr_mem,
  output logic [9:0] heart_sample,
  output logic [1:0] heart_size,
  output logic [9:0] memory_high,
  output logic [9:0] memory_low,
  output logic       beat,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ATTACK = 2'd1,
    S_HOLD   = 2'd2,
    S_DECAY  = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_FRAMES - 1);
  localparam logic [9:0] DSTEP       = 10'(DECAY_STEP);

  state_t     state_q, state_d;
  logic [9:0] peak_acc_q, peak_acc_d;
  logic [9:0] peak_frame;
  logic [9:0] hs_q, hs_d;
  logic [1:0] size_q, size_d;
  logic [7:0] cnt_q, cnt_d;
  logic       beat_q, beat_d;
  logic       new_beat;
  logic [9:0] mem_hi_q, mem_hi_d;
  logic [9:0] mem_lo_q, mem_lo_d;
  logic       take_sample;

  // Running per-frame peak; a sample in the tick cycle closes the old frame only.
  always_comb begin
    take_sample = sample_valid && (sample_in > peak_acc_q);
    peak_frame  = take_sample ? sample_in : peak_acc_q;
    peak_acc_d  = peak_acc_q;
    if (frame_tick) begin
      peak_acc_d = '0;
    end else if (take_sample) begin
      peak_acc_d = sample_in;
    end
  end

  // Envelope FSM next-state; everything moves only on a frame tick.
  always_comb begin
    state_d  = state_q;
    hs_d     = hs_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    beat_d   = 1'b0;
    new_beat = 1'b0;
    if (frame_tick) begin
      if (!en || (size_sel == 2'd0)) begin
        state_d = S_IDLE;
        hs_d    = '0;
        size_d  = '0;
      end else begin
        size_d = size_sel;
        case (state_q)
          S_IDLE: begin
            state_d  = S_ATTACK;
            hs_d     = peak_frame;
            new_beat = 1'b1;
          end
          S_ATTACK: begin
            state_d = S_HOLD;
            cnt_d   = HOLD_RELOAD;
            if (peak_frame > hs_q) begin
              hs_d     = peak_frame;
              new_beat = 1'b1;
            end
          end
          S_HOLD: begin
            if (peak_frame > hs_q) begin
              hs_d     = peak_frame;
              cnt_d    = HOLD_RELOAD;
              new_beat = 1'b1;
            end else if (cnt_q == 8'd0) begin
              state_d = S_DECAY;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
          default: begin
            if (peak_frame > hs_q) begin
              state_d  = S_ATTACK;
              hs_d     = peak_frame;
              new_beat = 1'b1;
            end else if (hs_q > DSTEP) begin
              hs_d = hs_q - DSTEP;
            end else begin
              hs_d    = '0;
              state_d = S_IDLE;
            end
          end
        endcase
      end
      // Back-to-back ticks must not stretch beat past one cycle.
      beat_d = new_beat && !beat_q;
    end
  end

  // Peak memories track every frame regardless of enable; a clear beats a tick.
  always_comb begin
    mem_hi_d = mem_hi_q;
    mem_lo_d = mem_lo_q;
    if (clr_mem) begin
      mem_hi_d = '0;
      mem_lo_d = 10'h3FF;
    end else if (frame_tick) begin
      if (peak_frame > mem_hi_q) begin
        mem_hi_d = peak_frame;
      end
      if ((peak_frame != 10'd0) && (peak_frame < mem_lo_q)) begin
        mem_lo_d = peak_frame;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      peak_acc_q <= '0;
      hs_q       <= '0;
      size_q     <= '0;
      cnt_q      <= '0;
      beat_q     <= 1'b0;
      mem_hi_q   <= '0;
      mem_lo_q   <= 10'h3FF;
    end else begin
      state_q    <= state_d;
      peak_acc_q <= peak_acc_d;
      hs_q       <= hs_d;
      size_q     <= size_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      mem_hi_q   <= mem_hi_d;
      mem_lo_q   <= mem_lo_d;
    end
  end

  assign heart_sample = hs_q;
  assign heart_size   = size_q;
  assign memory_high  = mem_hi_q;
  assign memory_low   = mem_lo_q;
  assign beat         = beat_q;
  assign state        = state_q;

endmodule
